// File: rtl/simd_warp_receiver.sv
// rtl/simd_warp_receiver.sv - per-core warp dispatch receiver that slices a kernel into lane batches
package simd_warp_pkg;
    localparam int NUM_SIMD_CORES  = 4;
    localparam int LOG2_SIMD_CORES = 2;
    localparam int THREAD_W        = 16;
    localparam int PC_W            = 32;
    localparam int WARP_W          = 6;

    typedef struct packed {
        logic [THREAD_W-1:0] thread_count;
        logic [PC_W-1:0]     start_pc;
        logic [WARP_W-1:0]   warp_id;
    } kernel_t;
endpackage

module simd_warp_receiver
    import simd_warp_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int LANES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kernel_valid,
    input  logic [LOG2_SIMD_CORES-1:0] simd_core_id,
    input  kernel_t                    kernel_in,
    output logic                       batch_valid,
    input  logic                       batch_ready,
    output logic [PC_W-1:0]            batch_pc,
    output logic [WARP_W-1:0]          batch_warp_id,
    output logic [THREAD_W-1:0]        batch_base,
    output logic [LANES-1:0]           lane_mask,
    input  logic                       batch_done,
    output logic [LOG2_SIMD_CORES-1:0] freed_simd_core,
    output logic                       is_simd_free,
    output logic                       busy,
    output logic                       dispatch_overrun
);
    // One extra bit so issued + LANES never wraps for thread counts near the maximum
    localparam int CW = THREAD_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t        state;
    state_t        next_state;
    kernel_t       kern;
    logic [CW-1:0] issued;
    logic [CW-1:0] next_issued;
    logic [CW-1:0] thread_count_w;
    logic          id_match;
    logic          accept;
    logic          overrun;

    assign id_match       = kernel_valid && (simd_core_id == LOG2_SIMD_CORES'(CORE_ID));
    assign accept         = id_match && (state == IDLE);
    assign thread_count_w = {1'b0, kern.thread_count};
    assign next_issued    = issued + CW'(LANES);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (kernel_in.thread_count == '0) ? RELEASE : ISSUE;
                end
            end
            ISSUE: begin
                if (batch_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (batch_done) begin
                    next_state = (next_issued >= thread_count_w) ? RELEASE : ISSUE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Held kernel, issue progress and the sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kern    <= '0;
            issued  <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                kern   <= kernel_in;
                issued <= '0;
            end else if (state == WAIT && batch_done) begin
                issued <= next_issued;
            end
            if (id_match && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    // Lane i is active while its global thread index is below thread_count
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (issued + CW'(i)) < thread_count_w;
        end
    end

    assign batch_valid      = (state == ISSUE);
    assign busy             = (state != IDLE);
    assign is_simd_free     = (state == RELEASE);
    assign batch_pc         = kern.start_pc;
    assign batch_warp_id    = kern.warp_id;
    assign batch_base       = issued[THREAD_W-1:0];
    assign freed_simd_core  = LOG2_SIMD_CORES'(CORE_ID);
    assign dispatch_overrun = overrun;

endmodule

// File: tb/tb_simd_warp_receiver.sv
// tb/tb_simd_warp_receiver.sv - directed self-checking bench for simd_warp_receiver
module tb_simd_warp_receiver;
    import simd_warp_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       kernel_valid = 1'b0;
    logic [LOG2_SIMD_CORES-1:0] simd_core_id = '0;
    kernel_t                    kernel_in = '0;
    logic                       batch_valid;
    logic                       batch_ready = 1'b0;
    logic [PC_W-1:0]            batch_pc;
    logic [WARP_W-1:0]          batch_warp_id;
    logic [THREAD_W-1:0]        batch_base;
    logic [3:0]                 lane_mask;
    logic                       batch_done = 1'b0;
    logic [LOG2_SIMD_CORES-1:0] freed_simd_core;
    logic                       is_simd_free;
    logic                       busy;
    logic                       dispatch_overrun;

    int checks = 0;
    int errors = 0;
    int free_count = 0;

    simd_warp_receiver #(.CORE_ID(2), .LANES(4)) dut (
        .clk(clk), .rst(rst),
        .kernel_valid(kernel_valid), .simd_core_id(simd_core_id), .kernel_in(kernel_in),
        .batch_valid(batch_valid), .batch_ready(batch_ready),
        .batch_pc(batch_pc), .batch_warp_id(batch_warp_id), .batch_base(batch_base),
        .lane_mask(lane_mask), .batch_done(batch_done),
        .freed_simd_core(freed_simd_core), .is_simd_free(is_simd_free),
        .busy(busy), .dispatch_overrun(dispatch_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (is_simd_free) free_count = free_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [1:0] id, input int tc, input int pc, input int wid);
        kernel_valid = 1'b1;
        simd_core_id = id;
        kernel_in.thread_count = THREAD_W'(tc);
        kernel_in.start_pc = PC_W'(pc);
        kernel_in.warp_id = WARP_W'(wid);
        tick();
        kernel_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({batch_valid, is_simd_free, busy, dispatch_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000", {batch_valid, is_simd_free, busy, dispatch_overrun});
        end
        checks++;
        if (lane_mask !== 4'b0 || batch_base !== '0 || batch_pc !== '0 || batch_warp_id !== '0) begin
            errors++;
            $display("FAIL reset_fields got mask=%b base=%0d pc=%h warp=%0d expected zeros", lane_mask, batch_base, batch_pc, batch_warp_id);
        end
        checks++;
        if (freed_simd_core !== 2'd2) begin
            errors++;
            $display("FAIL reset_freed_id got %0d expected 2", freed_simd_core);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_multi_batch();
        logic [3:0] exp_mask [3] = '{4'b1111, 4'b1111, 4'b0011};
        free_count = 0;
        dispatch(2'd2, 10, 'h40, 5);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (batch_valid !== 1'b1 || batch_base !== THREAD_W'(b * 4) || lane_mask !== exp_mask[b]
                || batch_pc !== 32'h40 || batch_warp_id !== 6'd5) begin
                errors++;
                $display("FAIL multi_batch%0d got v=%b base=%0d mask=%b pc=%h warp=%0d expected v=1 base=%0d mask=%b pc=40 warp=5",
                         b, batch_valid, batch_base, lane_mask, batch_pc, batch_warp_id, b * 4, exp_mask[b]);
            end
            batch_ready = 1'b1;
            tick();
            batch_ready = 1'b0;
            checks++;
            if (batch_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL multi_wait%0d got v=%b busy=%b expected v=0 busy=1", b, batch_valid, busy);
            end
            tick();
            batch_done = 1'b1;
            tick();
            batch_done = 1'b0;
        end
        checks++;
        if (is_simd_free !== 1'b1 || freed_simd_core !== 2'd2 || batch_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_release got free=%b id=%0d v=%b expected free=1 id=2 v=0", is_simd_free, freed_simd_core, batch_valid);
        end
        tick();
        tick();
        checks++;
        if (free_count !== 1 || busy !== 1'b0 || is_simd_free !== 1'b0) begin
            errors++;
            $display("FAIL multi_single_pulse got pulses=%0d busy=%b expected pulses=1 busy=0", free_count, busy);
        end
    endtask

    task automatic test_other_core();
        int bad = 0;
        dispatch(2'd1, 8, 'h80, 1);
        for (int c = 0; c < 5; c++) begin
            if (batch_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || dispatch_overrun !== 1'b0) begin
            errors++;
            $display("FAIL other_core got bad_cycles=%0d overrun=%b expected 0 and 0", bad, dispatch_overrun);
        end
    endtask

    task automatic test_zero_threads();
        free_count = 0;
        dispatch(2'd2, 0, 'h10, 2);
        checks++;
        if (is_simd_free !== 1'b1 || batch_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_release got free=%b v=%b expected free=1 v=0", is_simd_free, batch_valid);
        end
        tick();
        checks++;
        if (is_simd_free !== 1'b0 || busy !== 1'b0 || batch_valid !== 1'b0 || free_count !== 1) begin
            errors++;
            $display("FAIL zero_idle got free=%b busy=%b v=%b pulses=%0d expected 0 0 0 1", is_simd_free, busy, batch_valid, free_count);
        end
    endtask

    task automatic test_overrun();
        int bad = 0;
        free_count = 0;
        dispatch(2'd2, 6, 'h200, 9);
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        dispatch(2'd2, 16, 'h300, 11);
        checks++;
        if (dispatch_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got %b expected 1", dispatch_overrun);
        end
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        checks++;
        if (batch_valid !== 1'b1 || batch_base !== 16'd4 || lane_mask !== 4'b0011
            || batch_pc !== 32'h200 || batch_warp_id !== 6'd9) begin
            errors++;
            $display("FAIL overrun_batch1 got v=%b base=%0d mask=%b pc=%h warp=%0d expected v=1 base=4 mask=0011 pc=200 warp=9",
                     batch_valid, batch_base, lane_mask, batch_pc, batch_warp_id);
        end
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (batch_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || free_count !== 1 || dispatch_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_dropped got bad_cycles=%0d pulses=%0d overrun=%b expected 0 1 1", bad, free_count, dispatch_overrun);
        end
    endtask

    task automatic test_reset_midway();
        free_count = 0;
        dispatch(2'd2, 12, 'h80, 3);
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if ({batch_valid, is_simd_free, busy, dispatch_overrun} !== 4'b0000 || lane_mask !== 4'b0
            || batch_base !== '0 || batch_pc !== '0 || batch_warp_id !== '0 || freed_simd_core !== 2'd2) begin
            errors++;
            $display("FAIL midway_reset got v=%b free=%b busy=%b ovr=%b mask=%b base=%0d pc=%h warp=%0d id=%0d expected all zero id=2",
                     batch_valid, is_simd_free, busy, dispatch_overrun, lane_mask, batch_base, batch_pc, batch_warp_id, freed_simd_core);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        dispatch(2'd2, 4, 'h44, 1);
        checks++;
        if (batch_valid !== 1'b1 || batch_base !== 16'd0 || lane_mask !== 4'b1111 || batch_pc !== 32'h44) begin
            errors++;
            $display("FAIL midway_new got v=%b base=%0d mask=%b pc=%h expected v=1 base=0 mask=1111 pc=44",
                     batch_valid, batch_base, lane_mask, batch_pc);
        end
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        tick();
        checks++;
        if (free_count !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midway_release got pulses=%0d busy=%b expected 1 0", free_count, busy);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        free_count = 0;
        dispatch(2'd2, 5, 'h100, 7);
        for (int c = 0; c < 5; c++) begin
            if (batch_valid !== 1'b1 || batch_pc !== 32'h100 || batch_base !== 16'd0 || lane_mask !== 4'b1111) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold got unstable_cycles=%0d expected 0", bad);
        end
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        checks++;
        if (batch_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drop got v=%b expected 0", batch_valid);
        end
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        checks++;
        if (batch_valid !== 1'b1 || batch_base !== 16'd4 || lane_mask !== 4'b0001) begin
            errors++;
            $display("FAIL stall_tail got v=%b base=%0d mask=%b expected v=1 base=4 mask=0001", batch_valid, batch_base, lane_mask);
        end
        batch_ready = 1'b1;
        tick();
        batch_ready = 1'b0;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        tick();
        checks++;
        if (free_count !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got pulses=%0d busy=%b expected 1 0", free_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_multi_batch();
        test_other_core();
        test_zero_threads();
        test_overrun();
        test_reset_midway();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
